matmul_seq_ctrl: RTL and testbench



---
 rtl/matmul_seq_ctrl_pkg.sv | 20 ++
 rtl/matmul_seq_ctrl_if.sv | 37 +++
 rtl/matmul_seq_ctrl_mac.sv | 50 +++++
 rtl/matmul_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared types for the sequential matrix-product controller: FSM states,
// default data width and a helper that sizes address/counter buses.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAST,
    WRITE,
    DONE
  } state_t;

  localparam int DATA_W_DEF = 32;

  // Width able to index 0..depth-1; never below 1 so 1x1 products still elaborate.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Control/memory bundle of matmul_seq_ctrl. master = controller side,
// slave = the environment (host plus A/B/C memories).
interface matmul_seq_ctrl_if
  import matmul_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int SIZE_C = 8,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int A_AW = addr_w(SIZE_A * SIZE_B);
  localparam int B_AW = addr_w(SIZE_B * SIZE_C);
  localparam int C_AW = addr_w(SIZE_A * SIZE_C);

  logic                     start;
  logic                     abort;
  logic                     busy;
  logic                     done;
  logic [A_AW-1:0]          a_addr;
  logic signed [DATA_W-1:0] a_rdata;
  logic [B_AW-1:0]          b_addr;
  logic signed [DATA_W-1:0] b_rdata;
  logic                     c_we;
  logic [C_AW-1:0]          c_addr;
  logic signed [DATA_W-1:0] c_wdata;

  modport master (
    input  start, abort, a_rdata, b_rdata,
    output busy, done, a_addr, b_addr, c_we, c_addr, c_wdata
  );

  modport slave (
    output start, abort, a_rdata, b_rdata,
    input  busy, done, a_addr, b_addr, c_we, c_addr, c_wdata
  );

endinterface

// File: rtl/matmul_seq_ctrl_mac.sv
// Single multiply-accumulate for the matrix product. Wrap-around arithmetic by
// default; define MATMUL_SAT_EN to saturate both the product and the running sum.
module mac_unit #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] acc
);
  logic signed [DATA_W-1:0] acc_reg;
  logic signed [DATA_W-1:0] prod_t;
  logic signed [DATA_W-1:0] sum;

`ifdef MATMUL_SAT_EN
  localparam logic signed [DATA_W-1:0] MAX_W = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_W = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [DATA_W:0]     sum_wide;

  assign prod_full = a * b;

  always_comb begin
    prod_t = prod_full[DATA_W-1:0];
    // Product fits only when its top DATA_W+1 bits are a pure sign extension.
    if (prod_full[2*DATA_W-1:DATA_W-1] != '0 && prod_full[2*DATA_W-1:DATA_W-1] != '1)
      prod_t = prod_full[2*DATA_W-1] ? MIN_W : MAX_W;
    sum_wide = {acc_reg[DATA_W-1], acc_reg} + {prod_t[DATA_W-1], prod_t};
    sum      = sum_wide[DATA_W-1:0];
    if (sum_wide[DATA_W] != sum_wide[DATA_W-1])
      sum = sum_wide[DATA_W] ? MIN_W : MAX_W;
  end
`else
  assign prod_t = a * b;
  assign sum    = acc_reg + prod_t;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)   acc_reg <= '0;
    else if (clr) acc_reg <= '0;
    else if (en)  acc_reg <= sum;
  end

  assign acc = acc_reg;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequential C = A x B controller: walks (i, j, k), drives A/B read addresses,
// feeds mac_unit and writes each C element. MATMUL_SAT_EN selects saturating MAC.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int SIZE_C = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  matmul_seq_ctrl_if.master bus
);
  localparam int I_W  = addr_w(SIZE_A);
  localparam int J_W  = addr_w(SIZE_C);
  localparam int K_W  = addr_w(SIZE_B);
  localparam int A_AW = addr_w(SIZE_A * SIZE_B);
  localparam int B_AW = addr_w(SIZE_B * SIZE_C);
  localparam int C_AW = addr_w(SIZE_A * SIZE_C);

  localparam logic [I_W-1:0] I_LAST = I_W'(SIZE_A - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(SIZE_C - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(SIZE_B - 1);

  state_t                   state_reg, state_next;
  logic [I_W-1:0]           i_reg, i_next;
  logic [J_W-1:0]           j_reg, j_next;
  logic [K_W-1:0]           k_reg, k_next;
  logic                     mac_clr, mac_en;
  logic signed [DATA_W-1:0] acc;
  logic                     c_we_reg;
  logic [C_AW-1:0]          c_addr_reg;
  logic signed [DATA_W-1:0] c_hold_reg;

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = FETCH;
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
        end
      end
      FETCH: begin
        // Data for k-1 arrives this cycle; k=0 has nothing yet, so clear instead.
        mac_clr = (k_reg == '0);
        mac_en  = (k_reg != '0);
        if (k_reg == K_LAST) begin
          k_next     = '0;
          state_next = LAST;
        end else begin
          k_next = k_reg + K_W'(1);
        end
      end
      LAST: begin
        mac_en     = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        state_next = FETCH;
        if (j_reg == J_LAST) begin
          j_next = '0;
          if (i_reg == I_LAST) begin
            i_next     = '0;
            state_next = DONE;
          end else begin
            i_next = i_reg + I_W'(1);
          end
        end else begin
          j_next = j_reg + J_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort wins over everything, including a start seen in the same IDLE cycle.
    if (bus.abort) begin
      state_next = IDLE;
      i_next     = '0;
      j_next     = '0;
      k_next     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      c_we_reg   <= 1'b0;
      c_addr_reg <= '0;
      c_hold_reg <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      c_we_reg  <= (state_reg == LAST) && !bus.abort;
      if (state_reg == LAST && !bus.abort)
        c_addr_reg <= C_AW'(int'(i_reg) * SIZE_C + int'(j_reg));
      if (c_we_reg)
        c_hold_reg <= acc;
    end
  end

  mac_unit #(.DATA_W(DATA_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (bus.a_rdata),
    .b     (bus.b_rdata),
    .acc   (acc)
  );

  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = (state_reg == DONE);
  assign bus.a_addr  = (state_reg == FETCH) ? A_AW'(int'(i_reg) * SIZE_B + int'(k_reg)) : '0;
  assign bus.b_addr  = (state_reg == FETCH) ? B_AW'(int'(k_reg) * SIZE_C + int'(j_reg)) : '0;
  assign bus.c_we    = c_we_reg;
  assign bus.c_addr  = c_addr_reg;
  // The accumulator is only final during WRITE; outside it the last written value is held.
  assign bus.c_wdata = c_we_reg ? acc : c_hold_reg;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized bench for matmul_seq_ctrl: three instances (2x2x2, 3x4x2, 1x1x1)
// checked cycle by cycle against a plain-arithmetic matrix-product model.
module tb_matmul_seq_ctrl;

  localparam int NI = 3;
  localparam int SA[NI] = '{2, 3, 1};
  localparam int SB[NI] = '{2, 4, 1};
  localparam int SC[NI] = '{2, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n [NI];
  logic                start [NI];
  logic                abort [NI];
  logic                busy_o [NI];
  logic                done_o [NI];
  logic                c_we_o [NI];
  int                  a_addr_o [NI];
  int                  b_addr_o [NI];
  int                  c_addr_o [NI];
  logic signed [31:0]  c_wdata_o [NI];
  logic signed [31:0]  a_mem [NI][16];
  logic signed [31:0]  b_mem [NI][16];
  longint              c_cap [NI][16];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    matmul_seq_ctrl_if #(.SIZE_A(SA[gi]), .SIZE_B(SB[gi]), .SIZE_C(SC[gi]), .DATA_W(32)) bus ();

    matmul_seq_ctrl #(.SIZE_A(SA[gi]), .SIZE_B(SB[gi]), .SIZE_C(SC[gi]), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n[gi]),
      .bus   (bus)
    );

    assign bus.start      = start[gi];
    assign bus.abort      = abort[gi];
    assign busy_o[gi]     = bus.busy;
    assign done_o[gi]     = bus.done;
    assign c_we_o[gi]     = bus.c_we;
    assign a_addr_o[gi]   = int'(bus.a_addr);
    assign b_addr_o[gi]   = int'(bus.b_addr);
    assign c_addr_o[gi]   = int'(bus.c_addr);
    assign c_wdata_o[gi]  = bus.c_wdata;

    // Memories with one cycle of read latency.
    always @(posedge clk) begin
      bus.a_rdata <= a_mem[gi][bus.a_addr];
      bus.b_rdata <= b_mem[gi][bus.b_addr];
    end
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j] in 32-bit wrap or saturating arithmetic.
  function automatic longint model_elem(input int n, input int i, input int j);
    longint acc = 0;
    longint p;
    for (int k = 0; k < SB[n]; k++) begin
      p = longint'(a_mem[n][i*SB[n]+k]) * longint'(b_mem[n][k*SC[n]+j]);
`ifdef MATMUL_SAT_EN
      acc = clamp32(acc + clamp32(p));
`else
      acc = longint'(int'(acc + longint'(int'(p))));
`endif
    end
    return acc;
  endfunction

  // One product on instance n. abort_cyc/rst_cyc/busy_start_cyc < 0 disables that event.
  task automatic run(input int n, input int abort_cyc, input int rst_cyc, input int busy_start_cyc);
    int per      = SB[n] + 2;
    int nelem    = SA[n] * SC[n];
    int done_cyc = nelem * per + 1;
    int stop     = (abort_cyc >= 0) ? abort_cyc : ((rst_cyc >= 0) ? rst_cyc : 1 << 30);
    int writes   = 0;
    longint exp_c[16];
    for (int e = 0; e < nelem; e++) exp_c[e] = model_elem(n, e / SC[n], e % SC[n]);
    for (int e = 0; e < 16; e++) c_cap[n][e] = -64'sd999999;
    @(negedge clk);
    start[n] = 1'b1;
    for (int cyc = 1; cyc <= done_cyc + 3; cyc++) begin
      int  e = (cyc - 1) / per;
      int  o = (cyc - 1) % per;
      bit  alive = (cyc <= stop);
      bit  exp_we = alive && cyc < done_cyc && o == per - 1;
      @(posedge clk);
      #1;
      if (cyc == 1) start[n] = 1'b0;
      check("busy", busy_o[n], alive && cyc <= done_cyc);
      check("c_we", c_we_o[n], exp_we);
      check("done", done_o[n], alive && cyc == done_cyc);
      if (exp_we) begin
        check("c_addr", c_addr_o[n], e);
        check("c_wdata", c_wdata_o[n], exp_c[e]);
      end
      if (alive && cyc < done_cyc && o < SB[n]) begin
        check("a_addr", a_addr_o[n], (e / SC[n]) * SB[n] + o);
        check("b_addr", b_addr_o[n], o * SC[n] + e % SC[n]);
      end else if (!alive || cyc > done_cyc) begin
        check("a_addr_idle", a_addr_o[n], 0);
        check("b_addr_idle", b_addr_o[n], 0);
      end
      if (c_we_o[n] === 1'b1) begin
        writes++;
        c_cap[n][c_addr_o[n] & 15] = c_wdata_o[n];
      end
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        check("rst_c_addr", c_addr_o[n], 0);
        check("rst_c_wdata", c_wdata_o[n], 0);
        rst_n[n] = 1'b1;
      end
      if (cyc == abort_cyc)          abort[n] = 1'b1;
      if (cyc == abort_cyc + 1)      abort[n] = 1'b0;
      if (cyc == rst_cyc)            rst_n[n] = 1'b0;
      if (cyc == busy_start_cyc)     start[n] = 1'b1;
      if (cyc == busy_start_cyc + 1) start[n] = 1'b0;
    end
    $display("run inst=%0d size=%0dx%0dx%0d abort=%0d rst=%0d writes=%0d", n, SA[n], SB[n], SC[n],
             abort_cyc, rst_cyc, writes);
  endtask

  task automatic fill_random(input int n, input bit big);
    for (int x = 0; x < 16; x++) begin
      if (big) begin
        a_mem[n][x] = $urandom;
        b_mem[n][x] = $urandom;
      end else begin
        a_mem[n][x] = $urandom_range(0, 200) - 100;
        b_mem[n][x] = $urandom_range(0, 200) - 100;
      end
    end
  endtask

  initial begin
    longint rs;
    for (int n = 0; n < NI; n++) begin
      rst_n[n] = 1'b0;
      start[n] = 1'b0;
      abort[n] = 1'b0;
      fill_random(n, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < NI; n++) begin
      check("reset_busy", busy_o[n], 0);
      check("reset_done", done_o[n], 0);
      check("reset_c_we", c_we_o[n], 0);
      check("reset_a_addr", a_addr_o[n], 0);
      check("reset_b_addr", b_addr_o[n], 0);
      check("reset_c_addr", c_addr_o[n], 0);
      check("reset_c_wdata", c_wdata_o[n], 0);
    end
    @(negedge clk);
    for (int n = 0; n < NI; n++) rst_n[n] = 1'b1;

    // 2x2x2 reference product, with a start pulse while busy.
    a_mem[0][0] = 1; a_mem[0][1] = 2; a_mem[0][2] = 3; a_mem[0][3] = 4;
    b_mem[0][0] = 5; b_mem[0][1] = 6; b_mem[0][2] = 7; b_mem[0][3] = 8;
    run(0, -1, -1, 3);
    check("c00", c_cap[0][0], 19);
    check("c01", c_cap[0][1], 22);
    check("c10", c_cap[0][2], 43);
    check("c11", c_cap[0][3], 50);

    // Abort in the second element's FETCH, then a clean rerun.
    run(0, 5, -1, -1);
    check("abort_c00", c_cap[0][0], 19);
    check("abort_c01_unwritten", c_cap[0][1], -64'sd999999);
    run(0, -1, -1, -1);
    check("rerun_c11", c_cap[0][3], 50);

    // start and abort together in IDLE: stays idle.
    @(negedge clk);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check("start_abort_busy", busy_o[0], 0);
    @(posedge clk);
    #1;
    check("start_abort_busy2", busy_o[0], 0);
    check("start_abort_a_addr", a_addr_o[0], 0);

    for (int r = 0; r < 3; r++) begin
      fill_random(0, r[0]);
      run(0, -1, -1, -1);
    end

    // Reset asserted in the second element's WRITE after a busy start.
    run(0, -1, 8, 2);

    // 3x4x2 with B of ones: each C element is the row sum of A.
    fill_random(1, 1'b0);
    for (int x = 0; x < 16; x++) b_mem[1][x] = 1;
    run(1, -1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      rs = 0;
      for (int k = 0; k < 4; k++) rs += longint'(a_mem[1][i*4+k]);
      for (int j = 0; j < 2; j++) check("rowsum", c_cap[1][i*2+j], rs);
    end
    for (int r = 0; r < 2; r++) begin
      fill_random(1, 1'b1);
      run(1, -1, -1, -1);
    end

    // 1x1x1 overflow and sign handling.
    a_mem[2][0] = 32'sh4000_0000;
    b_mem[2][0] = 4;
    run(2, -1, -1, -1);
`ifdef MATMUL_SAT_EN
    check("ovf_sat", c_cap[2][0], 64'sd2147483647);
`else
    check("ovf_wrap", c_cap[2][0], 0);
`endif
    a_mem[2][0] = -3;
    b_mem[2][0] = 5;
    run(2, -1, -1, -1);
    check("neg", c_cap[2][0], -15);
    for (int r = 0; r < 4; r++) begin
      fill_random(2, 1'b1);
      run(2, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
